ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_if.sv | 29 ++
 rtl/ex_mdu.sv | 163 ++++++++++++++++
 tb/tb_ex_mdu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// Request/writeback bundle between an issue stage and the ex_mdu multiply/divide unit.
interface ex_mdu_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [RD_W-1:0] rd_addr_i;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            rd_we;
  logic [RD_W-1:0] rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            busy;

  modport master (
    output in_valid, funct3, rs1_data, rs2_data, rd_addr_i, flush, out_ready,
    input  in_ready, out_valid, rd_we, rd_addr, rd_data, busy
  );

  modport slave (
    input  in_valid, funct3, rs1_data, rs2_data, rd_addr_i, flush, out_ready,
    output in_ready, out_valid, rd_we, rd_addr, rd_data, busy
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, then one sign-fix cycle.
// Define EX_MDU_DIV_EN to build the divider; without it divide ops retire with rd_we=0.
module ex_mdu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int             CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [RD_W-1:0]   rd_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              neg_reg;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   result_reg;
  logic              we_reg;

  logic              in_ready_c, accept;
  logic              a_signed, b_signed, a_neg, b_neg, res_neg, skip;
  logic [XLEN-1:0]   a_mag, b_mag, mcand_next;
  logic [2*XLEN-1:0] acc_init, step_next, prod_fix;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   fix_result;
  logic              fix_we;
`ifdef EX_MDU_DIV_EN
  logic [XLEN:0]     div_part, div_diff;
`endif

  assign in_ready_c = ((state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready)) & ~bus.flush;
  assign accept     = bus.in_valid & in_ready_c;

  // Operand decode at the accept edge: magnitudes, result sign and the CALC-skip cases.
  always_comb begin
    a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg    = a_signed & bus.rs1_data[XLEN-1];
    b_neg    = b_signed & bus.rs2_data[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
    res_neg  = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    skip     = 1'b0;
    if (bus.funct3[2]) begin
      mcand_next = b_mag;
      acc_init   = {{XLEN{1'b0}}, a_mag};
    end else begin
      mcand_next = a_mag;
      acc_init   = {{XLEN{1'b0}}, b_mag};
    end
`ifdef EX_MDU_DIV_EN
    // Special divides preload {remainder, quotient} directly so FIX passes them through.
    if (bus.funct3[2]) begin
      if (bus.rs2_data == '0) begin
        skip     = 1'b1;
        res_neg  = 1'b0;
        acc_init = {bus.rs1_data, {XLEN{1'b1}}};
      end else if (!bus.funct3[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (&bus.rs2_data)) begin
        skip     = 1'b1;
        res_neg  = 1'b0;
        acc_init = {{XLEN{1'b0}}, bus.rs1_data};
      end
    end
`else
    skip = bus.funct3[2];
`endif
  end

  // One iteration: shift-add multiply on {hi, multiplier} or restoring divide on {rem, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    step_next = {mul_sum, acc_reg[XLEN-1:1]};
`ifdef EX_MDU_DIV_EN
    div_part = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff = div_part - {1'b0, mcand_reg};
    if (op_reg[2]) begin
      step_next = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    prod_fix   = neg_reg ? -acc_reg : acc_reg;
    fix_result = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    fix_we     = 1'b1;
`ifdef EX_MDU_DIV_EN
    if (op_reg[2]) begin
      if (op_reg[1]) begin
        fix_result = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
      end else begin
        fix_result = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
      end
    end
`else
    if (op_reg[2]) begin
      fix_result = '0;
      fix_we     = 1'b0;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = skip ? FIX : CALC;
      CALC: if (cnt_reg == CNT_LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        if (accept) state_next = skip ? FIX : CALC;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      we_reg     <= 1'b0;
    end else if (accept) begin
      op_reg    <= bus.funct3;
      rd_reg    <= bus.rd_addr_i;
      mcand_reg <= mcand_next;
      acc_reg   <= acc_init;
      neg_reg   <= res_neg;
      cnt_reg   <= '0;
    end else if (state_reg == CALC) begin
      acc_reg <= step_next;
      cnt_reg <= cnt_reg + CW'(1);
    end else if (state_reg == FIX) begin
      result_reg <= fix_result;
      we_reg     <= fix_we;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.rd_we     = (state_reg == DONE) & we_reg;
  assign bus.rd_addr   = (state_reg == DONE) ? rd_reg : '0;
  assign bus.rd_data   = (state_reg == DONE) ? result_reg : '0;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed vectors, random ops against a plain-arithmetic model,
// stall/back-to-back, flush and asynchronous reset. Cycle counts treat the accept edge as cycle 1.
module tb_ex_mdu;
  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();
  ex_mdu #(.XLEN(XLEN), .RD_W(RD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Architectural result of an RV32M op, from integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, su, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    su = longint'({32'h0, b});
    case (f)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * su; return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; p = q; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected writeback and accept-to-valid cycle count for the build under test.
  task automatic expect_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output logic we, output int lat);
    data = ref_result(f, a, b);
    we   = 1'b1;
    lat  = XLEN + 2;
`ifdef EX_MDU_DIV_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat = 2;
`else
    if (f[2]) begin data = 32'h0; we = 1'b0; lat = 2; end
`endif
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'($urandom);
    bus.rs1_data  = $urandom;
    bus.rs2_data  = $urandom;
    bus.rd_addr_i = RD_W'($urandom);
  endtask

  // Present an op for one edge (caller ensures the unit can accept), then scramble inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [RD_W-1:0] rd);
    bus.in_valid  = 1'b1;
    bus.funct3    = f;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_addr_i = rd;
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (bus.out_valid !== 1'b1 && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.rd_we !== 1'b0) begin bad++; $display("FAIL reset_rd_we got=%b want=0", bus.rd_we); end
    total++; if (bus.rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", bus.rd_addr); end
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_directed();
    logic [2:0]  f_tab  [5] = '{3'b001, 3'b100, 3'b110, 3'b101, 3'b100};
    logic [31:0] a_tab  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] b_tab  [5] = '{32'h2, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] d_tab  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    int          l_tab  [5] = '{34, 34, 34, 2, 2};
    int          cycles;
    logic [31:0] want_d;
    logic        want_we;
    for (int i = 0; i < 5; i++) begin
      want_d  = d_tab[i];
      want_we = 1'b1;
`ifndef EX_MDU_DIV_EN
      if (f_tab[i][2]) begin want_d = 32'h0; want_we = 1'b0; l_tab[i] = 2; end
`endif
      issue(f_tab[i], a_tab[i], b_tab[i], 5'd5);
      wait_valid(cycles);
      total++; if (cycles != l_tab[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cycles, l_tab[i]); end
      total++; if (bus.rd_data !== want_d) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, bus.rd_data, want_d); end
      total++; if (bus.rd_we !== want_we) begin bad++; $display("FAIL dir%0d_we got=%b want=%b", i, bus.rd_we, want_we); end
      total++; if (bus.rd_addr !== 5'd5) begin bad++; $display("FAIL dir%0d_addr got=%0d want=5", i, bus.rd_addr); end
      $display("directed %0d: f=%b a=%h b=%h -> %h after %0d cycles", i, f_tab[i], a_tab[i], b_tab[i], bus.rd_data, cycles);
      consume();
    end
  endtask

  task automatic test_random();
    logic [2:0]      f;
    logic [31:0]     a, b, want_d;
    logic [RD_W-1:0] rd;
    logic            want_we;
    int              want_lat, cycles;
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      rd = RD_W'($urandom);
      expect_op(f, a, b, want_d, want_we, want_lat);
      issue(f, a, b, rd);
      wait_valid(cycles);
      total++; if (cycles != want_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, cycles, want_lat); end
      total++; if (bus.rd_data !== want_d) begin bad++; $display("FAIL rnd%0d_data f=%b a=%h b=%h got=%h want=%h", i, f, a, b, bus.rd_data, want_d); end
      total++; if (bus.rd_we !== want_we) begin bad++; $display("FAIL rnd%0d_we got=%b want=%b", i, bus.rd_we, want_we); end
      total++; if (bus.rd_addr !== rd) begin bad++; $display("FAIL rnd%0d_addr got=%0d want=%0d", i, bus.rd_addr, rd); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      consume();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_drop got=%b want=0", i, bus.out_valid); end
      $display("random %0d: f=%b a=%h b=%h rd=%0d -> %h we=%b", i, f, a, b, rd, bus.rd_data, bus.rd_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, want;
    int          cycles;
    a    = $urandom;
    b    = $urandom;
    want = a * b;
    issue(3'b000, a, b, 5'd12);
    wait_valid(cycles);
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.rd_data !== want || bus.rd_addr !== 5'd12)
        begin bad++; $display("FAIL stall%0d valid=%b data=%h addr=%0d want data=%h addr=12", i, bus.out_valid, bus.rd_data, bus.rd_addr, want); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.funct3    = 3'b011;
    bus.rs1_data  = 32'hFFFF_FFFF;
    bus.rs2_data  = 32'hFFFF_FFFF;
    bus.rd_addr_i = 5'd9;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    scramble();
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept valid=%b busy=%b want valid=0 busy=1", bus.out_valid, bus.busy); end
    wait_valid(cycles);
    total++; if (cycles != XLEN + 2) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cycles, XLEN + 2); end
    total++; if (bus.rd_data !== 32'hFFFF_FFFE || bus.rd_addr !== 5'd9) begin bad++; $display("FAIL b2b_result got=%h/%0d want=fffffffe/9", bus.rd_data, bus.rd_addr); end
    $display("back_to_back: stalled result %h, next result %h after %0d cycles", want, bus.rd_data, cycles);
    consume();
  endtask

  task automatic test_flush();
    int seen;
    issue(3'b001, $urandom, $urandom, 5'd3);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept got=%b want=0", bus.in_ready); end
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_calc busy=%b valid=%b want 0/0", bus.busy, bus.out_valid); end
    seen = 0;
    for (int i = 0; i < XLEN + 6; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_result got=%0d valid cycles want=0", seen); end
    issue(3'b011, $urandom, $urandom, 5'd4);
    wait_valid(seen);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.rd_we !== 1'b0) begin bad++; $display("FAIL flush_done valid=%b we=%b want 0/0", bus.out_valid, bus.rd_we); end
    $display("flush: op dropped in CALC and in DONE");
  endtask

  task automatic test_async_reset();
    int seen;
    issue(3'b000, $urandom, $urandom, 5'd7);
    repeat (19) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.rd_data !== '0 || bus.rd_addr !== '0)
      begin bad++; $display("FAIL arst_calc busy=%b in_ready=%b valid=%b data=%h addr=%0d want 0/1/0/0/0", bus.busy, bus.in_ready, bus.out_valid, bus.rd_data, bus.rd_addr); end
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < XLEN + 6; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL arst_no_result got=%0d want=0", seen); end
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    wait_valid(seen);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.rd_we !== 1'b0 || bus.rd_data !== '0 || bus.rd_addr !== '0)
      begin bad++; $display("FAIL arst_done valid=%b we=%b data=%h addr=%0d want all 0", bus.out_valid, bus.rd_we, bus.rd_data, bus.rd_addr); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    $display("async_reset: op discarded mid-CALC and in DONE");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_addr_i = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
